ps2_rx_checked: RTL
===================

Name: ps2_rx_checked

Overview:
Next-generation PS/2 device-to-host receiver running entirely on the system clock. The PS/2 clock is oversampled rather than used as a clock.
- Synchronises and deglitches both PS/2 lines.
- Checks start, odd-parity and stop bits.
- Aborts stalled frames on timeout.
- Can inhibit the device by holding the PS/2 clock low.
- Buffers received bytes in a small show-ahead FIFO.
- Sits between the PS/2 pads and the scan-code/controller logic.

Parameters:
DATA_BITS, 8, payload bits per frame, LSB first.
FIFO_DEPTH, 4, received-byte buffer depth; power of two, at least 2.
FILTER_LEN, 4, consecutive equal samples required before a filtered line changes.
TIMEOUT_CYC, 50000, CLK cycles allowed between falling edges inside a frame before abort.
INHIBIT_CYC, 5000, CLK cycles the PS/2 clock is held low after a detected error.

Ports:
CLK  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high.
ps2_clk_in  in  1  raw PS/2 clock pad input (asynchronous).
ps2_data_in  in  1  raw PS/2 data pad input (asynchronous).
ps2_clk_oe  out  1  1 = pad drives PS/2 clock low (open-drain); 0 = released.
block  in  1  host inhibit request.
rd_en  in  1  pop the FIFO head.
rd_data  out  DATA_BITS  FIFO head; meaningful only while rd_valid=1.
rd_valid  out  1  FIFO not empty.
fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes held in the FIFO.
parity_err  out  1  one-cycle pulse when a frame fails the parity check.
frame_err  out  1  one-cycle pulse on bad stop bit or timeout.
overflow  out  1  sticky; set when a good byte arrives while the FIFO is full; cleared only by reset.

Behaviour:
- Reset values:
  - FSM in IDLE; FIFO empty.
  - All outputs 0, including rd_data.
  - Filter outputs 1; edge detector history 1.
- Input conditioning:
  - Each line passes through a 2-FF synchroniser, then the filter.
  - The filtered value changes only after FILTER_LEN consecutive identical synchronised samples.
  - A falling edge (fe) is a 1-cycle strobe when the filtered clock goes 1->0.
  - Data is sampled from the filtered data line in the fe cycle.
- FSM states: IDLE, DATA, PARITY, STOP, INHIBIT.
  - IDLE: on fe with data=0 (start bit), clear the bit counter and go to DATA. On fe with data=1, ignore and stay.
  - DATA: on each fe, shift the bit in LSB first. After the DATA_BITS-th bit, go to PARITY.
  - PARITY: on fe, latch the parity bit and go to STOP.
  - STOP: on fe, evaluate the frame:
    - data=1 and odd parity over payload+parity: push into FIFO, go to IDLE.
    - Parity bad: pulse parity_err, go to INHIBIT.
    - Parity good, stop=0: pulse frame_err, go to INHIBIT.
    - Both bad: pulse both, go to INHIBIT.
  - INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYC cycles, then IDLE. fe events are ignored.
- Timeout: in DATA/PARITY/STOP, a counter resets on each fe. When it reaches TIMEOUT_CYC: discard the partial frame, pulse frame_err, go to IDLE with no inhibit.
- block:
  - While block=1, ps2_clk_oe=1 and the FSM is forced to IDLE the next cycle. Any partial frame is discarded silently, with no error pulse.
  - FIFO contents and reads are unaffected.
  - block has priority over INHIBIT and timeout.
  - ps2_clk_oe = block OR (state==INHIBIT).
- Latency: the push occurs in the stop-bit fe cycle; rd_valid/rd_data update on the next CLK edge.
- FIFO:
  - Show-ahead; rd_data reflects the head while rd_valid=1.
  - rd_en while empty is ignored.
  - Push while full: byte dropped, overflow set, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: the push succeeds, the pop is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: the frame is discarded, FIFO is flushed, and ps2_clk_oe is released on the next cycle.

Decomposition:
- Package ps2_pkg holds:
  - the state enum ps2_rx_state_t (IDLE, DATA, PARITY, STOP, INHIBIT);
  - constants PS2_START_BIT=0 and PS2_STOP_BIT=1;
  - the function odd_parity_ok().
- One natural sub-module, ps2_line_filter #(FILTER_LEN): 2-FF synchroniser plus run-length filter, with reset value 1. Instantiated twice.
- FIFO stays inline.

Test Plan:
- Defaults. Send 0x1C with parity 0 and stop 1 at a 60-cycle half-period -> rd_valid=1 with rd_data=0x1C one cycle after the 11th fe; no error pulses.
- Send 0xF0 with parity forced 0 -> parity_err pulses once; ps2_clk_oe high for exactly 5000 cycles; FIFO empty.
- Send 5 good bytes 0x01..0x05 with no reads -> fifo_count=4, overflow=1, head=0x01. Pop 4 -> 0x01..0x04 in order, rd_valid=0.
- Stop clock toggling after 6 data bits -> frame_err pulses once TIMEOUT_CYC after the last fe; FSM returns to IDLE; a subsequent good 0x29 is received correctly.
- Inject 2-cycle glitches on ps2_clk_in mid-frame (FILTER_LEN=4) -> no extra bits; byte 0x5A received intact.
- Assert block after the 4th data bit of 0x33 -> ps2_clk_oe=1, no push and no error pulses. Deassert, send 0x33 -> received.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types, frame constants and the parity helper for the PS/2 receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        INHIBIT
    } ps2_rx_state_t;

    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;

    // True when payload plus parity bit hold an odd number of ones.
    // Narrower payloads are zero-extended by the caller; zeros leave the XOR unchanged.
    function automatic logic odd_parity_ok(input logic [31:0] payload, input logic parity);
        return ((^payload) ^ parity) == 1'b1;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length deglitcher for one PS/2 line.
// Both lines idle high, so everything resets to 1.
module ps2_line_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int RW = $clog2(FILTER_LEN + 1);

    logic          sync_a;
    logic          sync_b;
    logic [RW-1:0] run;

    // Bring the asynchronous pad into the CLK domain.
    always_ff @(posedge CLK) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Flip the filtered value only after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge CLK) begin
        if (reset) begin
            filtered <= 1'b1;
            run      <= '0;
        end else if (sync_b == filtered) begin
            run <= '0;
        end else if (run == RW'(FILTER_LEN - 1)) begin
            filtered <= sync_b;
            run      <= '0;
        end else begin
            run <= run + RW'(1);
        end
    end

endmodule

// File: rtl/ps2_rx_checked.sv
// PS/2 device-to-host receiver: oversampled clock, frame checks, timeout,
// inhibit after errors and a show-ahead receive FIFO.
//
//   state   | meaning
//   IDLE    | waiting for a start bit on a falling PS/2 clock edge
//   DATA    | shifting payload bits in, LSB first
//   PARITY  | waiting for the parity bit
//   STOP    | waiting for the stop bit, then judging the frame
//   INHIBIT | holding the PS/2 clock low after a bad frame
module ps2_rx_checked
    import ps2_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int INHIBIT_CYC = 5000
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic                          ps2_clk_in,
    input  logic                          ps2_data_in,
    output logic                          ps2_clk_oe,
    input  logic                          block,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int BW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int TMR_MAX = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYC - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic                 clk_f;
    logic                 data_f;
    logic                 clk_hist;
    logic                 fe;

    ps2_rx_state_t        state;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [TW-1:0]        timer;
    logic                 frame_ok;
    logic                 push;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 do_pop;
    logic                 do_push;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .CLK      (CLK),
        .reset    (reset),
        .raw      (ps2_clk_in),
        .filtered (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .CLK      (CLK),
        .reset    (reset),
        .raw      (ps2_data_in),
        .filtered (data_f)
    );

    // Remember the previous filtered clock to find falling edges.
    always_ff @(posedge CLK) begin
        if (reset) clk_hist <= 1'b1;
        else       clk_hist <= clk_f;
    end

    assign fe = clk_hist & ~clk_f;

    assign frame_ok = odd_parity_ok(32'(shreg), par_bit);
    assign push     = (state == STOP) && fe && !block &&
                      (data_f == PS2_STOP_BIT) && frame_ok;

    // The shared timer counts down to the timeout inside a frame and to the
    // end of the inhibit window in INHIBIT; block overrides everything.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            timer      <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (block) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (fe && data_f == PS2_START_BIT) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            timer   <= TMO_LOAD;
                        end
                    end
                    DATA, PARITY, STOP: begin
                        if (fe) begin
                            timer <= TMO_LOAD;
                            case (state)
                                DATA: begin
                                    shreg <= {data_f, shreg[DATA_BITS-1:1]};
                                    if (bit_cnt == LAST_BIT) state <= PARITY;
                                    else bit_cnt <= bit_cnt + BW'(1);
                                end
                                PARITY: begin
                                    par_bit <= data_f;
                                    state   <= STOP;
                                end
                                default: begin
                                    if (frame_ok && data_f == PS2_STOP_BIT) begin
                                        state <= IDLE;
                                    end else begin
                                        parity_err <= !frame_ok;
                                        frame_err  <= (data_f != PS2_STOP_BIT);
                                        timer      <= INH_LOAD;
                                        state      <= INHIBIT;
                                    end
                                end
                            endcase
                        end else if (timer == '0) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            timer <= timer - TW'(1);
                        end
                    end
                    INHIBIT: begin
                        if (timer == '0) state <= IDLE;
                        else timer <= timer - TW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ps2_clk_oe = block | (state == INHIBIT);

    assign do_pop  = rd_en && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    // FIFO storage; stale entries are never exposed because rd_data is gated.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    assign rd_valid   = (count != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;

endmodule
